addr_decode_pipe: RTL and testbench

Registered, runtime-programmable address decoder. Maps a stream of request addresses to destination indices through a rule table written via a configuration port. Sits in front of crossbar/demux routing where the address map changes at runtime (peripheral remap, boot-time map load). Adds a valid/ready handshake, a one-cycle pipeline stage, per-rule enables, and decode-error logging.

---
 rtl/addr_decode_pipe_pkg.sv | 20 ++
 rtl/addr_rule_match.sv | 25 ++
 rtl/addr_decode_pipe.sv | 157 +++++++++++++++
 tb/tb_addr_decode_pipe.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_decode_pipe_pkg.sv
// Shared types and helpers for the runtime-programmable address decoder.
// Default address and rule types target a 32-bit address map.
package addr_decode_pipe_pkg;

   localparam int unsigned DefaultErrCntWidth = 16;

   typedef logic [31:0] default_addr_t;

   typedef struct packed {
      int unsigned   idx;
      default_addr_t start_addr;
      default_addr_t end_addr;
   } default_rule_t;

   // Index width that never collapses to zero bits for a single-entry set.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 32'd1;
   endfunction

endpackage

// File: rtl/addr_rule_match.sv
// Combinational single-rule matcher: range rule or base/mask (NAPOT) rule.
module addr_rule_match
   import addr_decode_pipe_pkg::*;
#(
   parameter bit  Napot  = 1'b0,
   parameter type addr_t = default_addr_t,
   parameter type rule_t = default_rule_t
) (
   input  addr_t addr,
   input  rule_t rule,
   input  logic  en,
   output logic  hit
);

   always_comb begin
      if (Napot) begin
         hit = en && ((addr & rule.end_addr) == (rule.start_addr & rule.end_addr));
      end else begin
         // An end address of zero means the range runs to the top of the map.
         hit = en && (addr >= rule.start_addr) &&
               ((addr < rule.end_addr) || (rule.end_addr == '0));
      end
   end

endmodule

// File: rtl/addr_decode_pipe.sv
// Registered address decoder with a writable rule table, one pipeline stage
// under valid/ready, highest-slot-wins priority and a sticky decode-error log.
module addr_decode_pipe
   import addr_decode_pipe_pkg::*;
#(
   parameter int unsigned NoIndices    = 32'd2,
   parameter int unsigned NoRules      = 32'd4,
   parameter type         addr_t       = default_addr_t,
   parameter type         rule_t       = default_rule_t,
   parameter bit          Napot        = 1'b0,
   parameter int unsigned ErrCntWidth  = DefaultErrCntWidth,
   parameter int unsigned IdxWidth     = idx_width(NoIndices),
   parameter int unsigned RuleSelWidth = idx_width(NoRules),
   parameter type         idx_t        = logic [IdxWidth-1:0]
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  addr_t                   req_addr_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output idx_t                    rsp_idx_o,
   output addr_t                   rsp_addr_o,
   output logic                    rsp_dec_error_o,
   input  logic                    cfg_we_i,
   input  logic [RuleSelWidth-1:0] cfg_sel_i,
   input  rule_t                   cfg_rule_i,
   input  logic                    cfg_en_i,
   input  logic                    en_default_idx_i,
   input  idx_t                    default_idx_i,
   output logic                    err_valid_o,
   output addr_t                   err_addr_o,
   output logic [ErrCntWidth-1:0]  err_cnt_o,
   input  logic                    err_clear_i
);

   rule_t               rules [NoRules];
   logic [NoRules-1:0]  rule_en;
   logic [NoRules-1:0]  hit;
   logic                cfg_sel_ok;
   logic                req_fire;
   idx_t                dec_idx;
   logic                dec_hit;
   logic                dec_err;
   logic                err_valid_d;
   addr_t               err_addr_d;
   logic [ErrCntWidth-1:0] err_cnt_d;

   assign cfg_sel_ok  = 32'(cfg_sel_i) < NoRules;
   // Stalling requests during a write keeps decode off a half-written map.
   assign req_ready_o = (!rsp_valid_o || rsp_ready_i) && !cfg_we_i;
   assign req_fire    = req_valid_i && req_ready_o;

   // NOTE: the rule table is a small register file, so it is reset like any
   // other state; an unreset table would route to garbage indices after boot.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NoRules; i++) rules[i] <= '0;
         rule_en <= '0;
      end else if (cfg_we_i && cfg_sel_ok) begin
         rules[cfg_sel_i]   <= cfg_rule_i;
         rule_en[cfg_sel_i] <= cfg_en_i;
      end
   end

   for (genvar r = 0; r < NoRules; r++) begin : g_match
      addr_rule_match #(
         .Napot  (Napot),
         .addr_t (addr_t),
         .rule_t (rule_t)
      ) u_match (
         .addr (req_addr_i),
         .rule (rules[r]),
         .en   (rule_en[r]),
         .hit  (hit[r])
      );
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the priority loop can leave a value held and infer a latch.
   always_comb begin
      dec_idx = '0;
      dec_hit = 1'b0;
      dec_err = 1'b0;
      for (int r = 0; r < NoRules; r++) begin
         if (hit[r]) begin
            dec_hit = 1'b1;
            dec_idx = idx_t'(rules[r].idx);
         end
      end
      if (!dec_hit) begin
         if (en_default_idx_i) dec_idx = default_idx_i;
         else                  dec_err = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_o     <= 1'b0;
         rsp_idx_o       <= '0;
         rsp_addr_o      <= '0;
         rsp_dec_error_o <= 1'b0;
      end else if (req_fire) begin
         rsp_valid_o     <= 1'b1;
         rsp_idx_o       <= dec_idx;
         rsp_addr_o      <= req_addr_i;
         rsp_dec_error_o <= dec_err;
      end else if (rsp_ready_i) begin
         rsp_valid_o     <= 1'b0;
      end
   end

   // Clear applies first, so an error loaded in the same cycle starts a fresh log.
   always_comb begin
      err_valid_d = err_clear_i ? 1'b0 : err_valid_o;
      err_cnt_d   = err_clear_i ? '0   : err_cnt_o;
      err_addr_d  = err_addr_o;
      if (req_fire && dec_err) begin
         if (err_cnt_d != '1) err_cnt_d = err_cnt_d + ErrCntWidth'(1);
         if (!err_valid_d) begin
            err_valid_d = 1'b1;
            err_addr_d  = req_addr_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_valid_o <= 1'b0;
         err_addr_o  <= '0;
         err_cnt_o   <= '0;
      end else begin
         err_valid_o <= err_valid_d;
         err_addr_o  <= err_addr_d;
         err_cnt_o   <= err_cnt_d;
      end
   end

`ifndef SYNTHESIS
   a_cfg_idx: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (cfg_we_i && cfg_sel_ok) |-> (cfg_rule_i.idx < NoIndices));

   if (!Napot) begin : g_range_chk
      a_cfg_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
         (cfg_we_i && cfg_sel_ok) |->
         ((cfg_rule_i.start_addr < cfg_rule_i.end_addr) || (cfg_rule_i.end_addr == '0)));
   end

   a_rsp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (rsp_valid_o && !rsp_ready_i) |=>
      (rsp_valid_o && $stable(rsp_idx_o) && $stable(rsp_addr_o) && $stable(rsp_dec_error_o)));
`endif

endmodule

// File: tb/tb_addr_decode_pipe.sv
// Scoreboard bench: one range decoder and one NAPOT decoder (2-bit error
// counter) share stimulus; a reference model predicts results and the error log.
module tb_addr_decode_pipe;
   import addr_decode_pipe_pkg::*;

   localparam int unsigned NR = 4;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  idx;
      logic        err;
   } exp_t;

   typedef struct {
      logic        v;
      logic [31:0] a;
      logic        rr;
      logic        we;
      int unsigned sel;
      int unsigned ridx;
      logic [31:0] s;
      logic [31:0] e;
      logic        en;
      logic        clr;
   } stim_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          req_valid = 1'b0, rsp_ready = 1'b0, cfg_we = 1'b0, cfg_en = 1'b0;
   logic          en_default = 1'b0, err_clear = 1'b0;
   logic [31:0]   req_addr = '0;
   logic [1:0]    cfg_sel = '0, default_idx = '0;
   default_rule_t cfg_rule = '0;

   logic          req_ready [2];
   logic          rsp_valid [2];
   logic          rsp_err   [2];
   logic          err_valid [2];
   logic [1:0]    rsp_idx   [2];
   logic [31:0]   rsp_addr  [2];
   logic [31:0]   err_addr  [2];
   logic [15:0]   err_cnt   [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int unsigned W = (g == 0) ? 16 : 2;
      logic [W-1:0] cnt;
      addr_decode_pipe #(
         .NoIndices   (4),
         .NoRules     (NR),
         .Napot       (g == 1),
         .ErrCntWidth (W)
      ) u_dut (
         .clk_i            (clk),
         .rst_ni           (rst_n),
         .req_valid_i      (req_valid),
         .req_ready_o      (req_ready[g]),
         .req_addr_i       (req_addr),
         .rsp_valid_o      (rsp_valid[g]),
         .rsp_ready_i      (rsp_ready),
         .rsp_idx_o        (rsp_idx[g]),
         .rsp_addr_o       (rsp_addr[g]),
         .rsp_dec_error_o  (rsp_err[g]),
         .cfg_we_i         (cfg_we),
         .cfg_sel_i        (cfg_sel),
         .cfg_rule_i       (cfg_rule),
         .cfg_en_i         (cfg_en),
         .en_default_idx_i (en_default),
         .default_idx_i    (default_idx),
         .err_valid_o      (err_valid[g]),
         .err_addr_o       (err_addr[g]),
         .err_cnt_o        (cnt),
         .err_clear_i      (err_clear)
      );
      assign err_cnt[g] = 16'(cnt);
   end

   // Reference model state
   int unsigned m_idx   [NR];
   logic [31:0] m_start [NR];
   logic [31:0] m_end   [NR];
   logic        m_en    [NR];
   logic        m_valid, m_valid_cur;
   logic        e_valid [2], e_valid_p [2];
   logic [31:0] e_addr  [2], e_addr_p  [2];
   int unsigned e_cnt   [2], e_cnt_p   [2];
   exp_t        q0 [$];
   exp_t        q1 [$];
   logic        g_den = 1'b0;
   logic [1:0]  g_didx = '0;
   bit          mon_on = 1'b0;
   bit          stall [2];
   logic [63:0] held  [2];
   int          n_tests = 0;
   int          n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Search from the top slot down; the first enabled match is the winner.
   function automatic void model_decode(input int g, input logic [31:0] a,
                                        output logic [1:0] idx, output logic err);
      bit hit;
      idx = '0;
      err = 1'b0;
      for (int r = NR - 1; r >= 0; r--) begin
         if (m_en[r]) begin
            if (g == 1) hit = (a & m_end[r]) == (m_start[r] & m_end[r]);
            else        hit = (a >= m_start[r]) && (m_end[r] == 0 || a < m_end[r]);
            if (hit) begin
               idx = m_idx[r][1:0];
               return;
            end
         end
      end
      if (g_den) idx = g_didx;
      else       err = 1'b1;
   endfunction

   task automatic cyc(input stim_t s);
      logic exp_rdy, acc, err;
      logic [1:0] idx;
      exp_t it;
      @(posedge clk);
      #1;
      m_valid_cur = m_valid;
      for (int g = 0; g < 2; g++) begin
         e_valid[g] = e_valid_p[g];
         e_addr[g]  = e_addr_p[g];
         e_cnt[g]   = e_cnt_p[g];
      end
      req_valid   = s.v;
      req_addr    = s.a;
      rsp_ready   = s.rr;
      cfg_we      = s.we;
      cfg_sel     = s.sel[1:0];
      cfg_rule    = '{idx: s.ridx, start_addr: s.s, end_addr: s.e};
      cfg_en      = s.en;
      err_clear   = s.clr;
      en_default  = g_den;
      default_idx = g_didx;
      #1;
      exp_rdy = (!m_valid || s.rr) && !s.we;
      check("req_ready_r", req_ready[0], exp_rdy);
      check("req_ready_n", req_ready[1], exp_rdy);
      acc = s.v && exp_rdy;
      for (int g = 0; g < 2; g++) begin
         model_decode(g, s.a, idx, err);
         if (acc) begin
            it = '{addr: s.a, idx: idx, err: err};
            if (g == 0) q0.push_back(it);
            else        q1.push_back(it);
         end
         if (s.clr) begin
            e_valid_p[g] = 1'b0;
            e_cnt_p[g]   = 0;
         end
         if (acc && err) begin
            if (e_cnt_p[g] < ((g == 0) ? 32'd65535 : 32'd3)) e_cnt_p[g]++;
            if (!e_valid_p[g]) begin
               e_valid_p[g] = 1'b1;
               e_addr_p[g]  = s.a;
            end
         end
      end
      m_valid = acc || (m_valid && !s.rr);
      if (s.we && s.sel < NR) begin
         m_idx[s.sel]   = s.ridx;
         m_start[s.sel] = s.s;
         m_end[s.sel]   = s.e;
         m_en[s.sel]    = s.en;
      end
   endtask

   function automatic stim_t idle(input logic rr = 1'b1);
      stim_t s;
      s = '{v: 1'b0, a: '0, rr: rr, we: 1'b0, sel: 0, ridx: 0, s: '0, e: '0, en: 1'b0, clr: 1'b0};
      return s;
   endfunction

   task automatic req(input logic [31:0] a, input logic rr = 1'b1, input logic clr = 1'b0);
      stim_t s = idle(rr);
      s.v = 1'b1;
      s.a = a;
      s.clr = clr;
      cyc(s);
   endtask

   task automatic wr(input int unsigned sel, input int unsigned ridx,
                     input logic [31:0] st, input logic [31:0] en_a, input logic en);
      stim_t s = idle();
      s.we = 1'b1;
      s.sel = sel;
      s.ridx = ridx;
      s.s = st;
      s.e = en_a;
      s.en = en;
      cyc(s);
   endtask

   task automatic do_reset();
      mon_on = 1'b0;
      rst_n = 1'b0;
      for (int r = 0; r < NR; r++) begin
         m_idx[r] = 0; m_start[r] = '0; m_end[r] = '0; m_en[r] = 1'b0;
      end
      m_valid = 1'b0;
      m_valid_cur = 1'b0;
      for (int g = 0; g < 2; g++) begin
         e_valid[g] = 1'b0; e_valid_p[g] = 1'b0;
         e_addr[g]  = '0;   e_addr_p[g]  = '0;
         e_cnt[g]   = 0;    e_cnt_p[g]   = 0;
         stall[g]   = 1'b0;
      end
      q0.delete();
      q1.delete();
      repeat (2) @(posedge clk);
      #1;
      req_valid = 1'b0; cfg_we = 1'b0; err_clear = 1'b0; rsp_ready = 1'b1;
      rst_n = 1'b1;
      #1;
      for (int g = 0; g < 2; g++) begin
         check("rst_rsp_valid", rsp_valid[g], 0);
         check("rst_rsp_fields", {rsp_idx[g], rsp_addr[g], rsp_err[g]}, 0);
         check("rst_err_log", {err_valid[g], err_addr[g], err_cnt[g]}, 0);
         check("rst_req_ready", req_ready[g], 1);
      end
      mon_on = 1'b1;
   endtask

   // Monitor: pops the scoreboard on each output handshake, tracks the error log.
   initial begin
      exp_t it;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            for (int g = 0; g < 2; g++) begin
               check("rsp_valid", rsp_valid[g], m_valid_cur);
               check("err_valid", err_valid[g], e_valid[g]);
               check("err_addr", err_addr[g], e_addr[g]);
               check("err_cnt", err_cnt[g], 64'(e_cnt[g]));
               if (stall[g])
                  check("hold_stable", {rsp_idx[g], rsp_addr[g], rsp_err[g]}, held[g]);
               stall[g] = rsp_valid[g] && !rsp_ready;
               held[g]  = 64'({rsp_idx[g], rsp_addr[g], rsp_err[g]});
               if (rsp_valid[g] && rsp_ready) begin
                  check("rsp_unexpected", (g == 0) ? q0.size() : q1.size(), (g == 0) ? 64'(q0.size() > 0 ? q0.size() : 1) : 64'(q1.size() > 0 ? q1.size() : 1));
                  if ((g == 0 && q0.size() > 0) || (g == 1 && q1.size() > 0)) begin
                     it = (g == 0) ? q0.pop_front() : q1.pop_front();
                     check("rsp_addr", rsp_addr[g], it.addr);
                     check("rsp_idx", rsp_idx[g], it.idx);
                     check("rsp_dec_error", rsp_err[g], it.err);
                  end
               end
            end
         end
      end
   end

   initial begin
      stim_t s;
      do_reset();

      // Basic hit and miss
      wr(0, 1, 32'h1000, 32'h2000, 1'b1);
      req(32'h1800);
      req(32'h3000);
      // Overlap: the higher slot wins, then disable it
      wr(1, 2, 32'h1000, 32'h1400, 1'b1);
      req(32'h1200);
      req(32'h1600);
      wr(1, 2, 32'h1000, 32'h1400, 1'b0);
      req(32'h1200);
      // Backpressure with back-to-back requests
      req(32'h1800);
      repeat (3) req(32'h1200, 1'b0);
      req(32'h1200);
      cyc(idle());
      cyc(idle());
      // Config write collides with a pending request
      s = idle();
      s.v = 1'b1; s.a = 32'h5000;
      s.we = 1'b1; s.sel = 2; s.ridx = 3; s.s = 32'h5000; s.e = 32'h6000; s.en = 1'b1;
      cyc(s);
      req(32'h5000);
      // Base/mask style rule, then default index
      wr(0, 3, 32'h4000_0000, 32'hF000_0000, 1'b1);
      req(32'h4ABC_0000);
      g_den = 1'b1; g_didx = 2'd2;
      req(32'h5000_0000);
      g_den = 1'b0;
      // Error log saturation and clear-with-error
      for (int i = 0; i < 5; i++) req(32'hF100_0000 + 32'(i * 16));
      req(32'hF200_0000, 1'b1, 1'b1);
      cyc(idle());

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         if (n % 50 == 0) begin
            g_den  = ($urandom_range(0, 2) == 0);
            g_didx = 2'($urandom_range(0, 3));
         end
         s = idle();
         s.v   = ($urandom_range(0, 3) != 0);
         s.a   = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 32'hBFFF));
         s.rr  = ($urandom_range(0, 3) != 0);
         s.we  = ($urandom_range(0, 9) == 0);
         s.sel = $urandom_range(0, NR - 1);
         s.ridx = $urandom_range(0, 3);
         s.s   = 32'($urandom_range(0, 32'h7F00));
         s.e   = ($urandom_range(0, 9) == 0) ? 32'h0 : s.s + 32'($urandom_range(1, 32'h4000));
         s.en  = ($urandom_range(0, 3) != 0);
         s.clr = ($urandom_range(0, 19) == 0);
         cyc(s);
      end
      g_den = 1'b0;
      repeat (3) cyc(idle());
      check("drain_q_range", q0.size(), 0);
      check("drain_q_napot", q1.size(), 0);

      // Reset with a held response and a write in flight
      req(32'h1800, 1'b0);
      cyc(idle(1'b0));
      @(posedge clk);
      #2;
      mon_on = 1'b0;
      cfg_we = 1'b1; cfg_sel = 2'd0; cfg_en = 1'b1;
      cfg_rule = '{idx: 0, start_addr: 32'h0, end_addr: 32'h0};
      rst_n = 1'b0;
      #1;
      check("rst_drop_valid_r", rsp_valid[0], 0);
      check("rst_drop_valid_n", rsp_valid[1], 0);
      do_reset();
      req(32'h0000_1800);
      req(32'h0000_0000);
      repeat (3) cyc(idle());
      check("final_q_range", q0.size(), 0);
      check("final_q_napot", q1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
